// File: rtl/pm_loader.sv
// Serial program loader for the PicoBlaze program memory. It frames UART bytes into
// 18-bit instructions, writes them to BRAM port A and answers each frame with ACK or NAK.
module pm_loader #(
  parameter logic [7:0]      START_BYTE     = 8'hA5,
  parameter logic [7:0]      ACK_BYTE       = 8'h06,
  parameter logic [7:0]      NAK_BYTE       = 8'h15,
  parameter int unsigned     TO_W           = 24,
  parameter logic [TO_W-1:0] TIMEOUT_CYCLES = TO_W'(5_000_000)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [9:0]  cpu_address,
  output logic [9:0]  pm_address,
  output logic [17:0] pm_data,
  output logic [3:0]  pm_we,
  output logic        cpu_reset,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_W0,
    S_W1,
    S_W2,
    S_CHK,
    S_RESP
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYCLES - TO_W'(1);

  state_t            r_state;
  state_t            w_state_nx;

  logic [TO_W-1:0]   r_timer;
  logic [9:0]        r_idx;
  logic [9:0]        r_last;
  logic [7:0]        r_sum;
  logic [1:0]        r_b0;
  logic [7:0]        r_b1;
  logic [17:0]       r_pm_data;
  logic [3:0]        r_pm_we;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_cpu_reset;
  logic              r_pass;

  logic              w_busy;
  logic              w_timing;
  logic              w_start;
  logic              w_expired;
  logic              w_handshake;
  logic [7:0]        w_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_start)  w_state_nx = S_CNT_HI;
      S_CNT_HI: if (rx_valid) w_state_nx = S_CNT_LO;
      S_CNT_LO: if (rx_valid) w_state_nx = S_W0;
      S_W0:     if (rx_valid) w_state_nx = S_W1;
      S_W1:     if (rx_valid) w_state_nx = S_W2;
      S_W2:     if (rx_valid) w_state_nx = (r_idx == r_last) ? S_CHK : S_W0;
      S_CHK:    if (rx_valid) w_state_nx = S_RESP;
      S_RESP:   if (w_handshake) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
    if (w_expired) begin
      w_state_nx = S_RESP;
    end
  end

  // State-derived decodes
  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_timing    = w_busy && (r_state != S_RESP);
    w_start     = (r_state == S_IDLE) && rx_valid && (rx_data == START_BYTE);
    // An arriving byte always beats the timeout in the same cycle.
    w_expired   = w_timing && !rx_valid && (r_timer == TO_LAST);
    w_handshake = (r_state == S_RESP) && r_tx_valid && tx_ready;
    w_sum       = r_sum + rx_data;
  end

  // Datapath: word assembly, checksum, write pulse, response and timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer     <= '0;
      r_idx       <= '0;
      r_last      <= '0;
      r_sum       <= '0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_pm_data   <= '0;
      r_pm_we     <= '0;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_cpu_reset <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_pm_we <= '0;

      if (rx_valid || !w_timing || w_expired) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TO_W'(1);
      end

      if (w_timing && rx_valid) begin
        r_sum <= w_sum;
      end

      // The index advances in the cycle the write is presented, so the
      // write address seen on pm_address is still the old index.
      if (r_pm_we != '0) begin
        r_idx <= r_idx + 10'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cpu_reset <= 1'b1;
            r_sum       <= '0;
            r_idx       <= '0;
          end
        end
        S_CNT_HI: if (rx_valid) r_last[9:8] <= rx_data[1:0];
        S_CNT_LO: if (rx_valid) r_last[7:0] <= rx_data;
        S_W0:     if (rx_valid) r_b0 <= rx_data[1:0];
        S_W1:     if (rx_valid) r_b1 <= rx_data;
        S_W2: begin
          if (rx_valid) begin
            r_pm_we   <= 4'b0011;
            r_pm_data <= {r_b0, r_b1, rx_data};
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            r_tx_valid <= 1'b1;
            r_pass     <= (w_sum == 8'h00);
            r_tx_data  <= (w_sum == 8'h00) ? ACK_BYTE : NAK_BYTE;
          end
        end
        S_RESP: begin
          if (w_handshake) begin
            r_tx_valid <= 1'b0;
            if (r_pass) begin
              r_cpu_reset <= 1'b0;
            end
          end
        end
        default: ;
      endcase

      if (w_expired) begin
        r_tx_valid <= 1'b1;
        r_pass     <= 1'b0;
        r_tx_data  <= NAK_BYTE;
      end
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign pm_data    = r_pm_data;
  assign pm_we      = r_pm_we;
  assign cpu_reset  = r_cpu_reset;
  assign busy       = w_busy;
  assign pm_address = w_busy ? r_idx : cpu_address;

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: randomized load frames driven against a frame-level reference
// model and a behavioural program-memory array attached to the BRAM port.
module tb_pm_loader;

  localparam int unsigned TO    = 16;
  localparam logic [7:0]  START = 8'hA5;
  localparam logic [7:0]  ACK   = 8'h06;
  localparam logic [7:0]  NAK   = 8'h15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [9:0]  cpu_address = '0;
  logic [9:0]  pm_address;
  logic [17:0] pm_data;
  logic [3:0]  pm_we;
  logic        cpu_reset;
  logic        busy;

  always #5 clk = ~clk;

  pm_loader #(
    .START_BYTE    (START),
    .ACK_BYTE      (ACK),
    .NAK_BYTE      (NAK),
    .TO_W          (24),
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cpu_address(cpu_address),
    .pm_address (pm_address),
    .pm_data    (pm_data),
    .pm_we      (pm_we),
    .cpu_reset  (cpu_reset),
    .busy       (busy)
  );

  // Behavioural program memory on port A
  logic [17:0] ram [1024];
  always @(posedge clk) if (pm_we != 4'b0000) ram[pm_address] <= pm_data;

  typedef struct packed {
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [17:0] data;
  } wr_t;
  wr_t wq[$];
  always @(negedge clk) if (pm_we !== 4'b0000) wq.push_back({pm_we, pm_address, pm_data});

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          exp_cpu_reset = 1'b0;
  logic [17:0] words[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int unsigned gmin, input int unsigned gmax);
    repeat ($urandom_range(gmax, gmin)) tick();
  endtask

  task automatic handshake(input bit nak);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    if (!nak) exp_cpu_reset = 1'b0;
    chk("hs_tx_valid", 32'(tx_valid), 0);
    chk("hs_busy", 32'(busy), 0);
    chk("hs_cpu_reset", 32'(cpu_reset), 32'(exp_cpu_reset));
    cpu_address = 10'($urandom);
    #1;
    chk("hs_pm_addr_pass", 32'(pm_address), 32'(cpu_address));
  endtask

  // Sends a complete frame carrying the contents of `words`, checks every write,
  // the response and cpu_reset. `bad` corrupts CHK by +1; `hold` keeps tx_ready low
  // that many cycles while stray bytes arrive.
  task automatic run_frame(input bit bad, input int unsigned gmin, input int unsigned gmax,
                           input int unsigned hold);
    int unsigned n;
    int unsigned nbad;
    logic [9:0]  cnt;
    logic [7:0]  hi, b0, sum, c, resp;
    logic [7:0]  stray [3];
    n   = words.size();
    cnt = 10'(n - 1);
    hi  = {6'($urandom), cnt[9:8]};
    sum = hi + cnt[7:0];
    wq.delete();
    strobe(START);
    exp_cpu_reset = 1'b1;
    chk("start_busy", 32'(busy), 1);
    chk("start_cpu_reset", 32'(cpu_reset), 1);
    gap(gmin, gmax);
    strobe(hi);
    gap(gmin, gmax);
    strobe(cnt[7:0]);
    gap(gmin, gmax);
    for (int unsigned i = 0; i < n; i++) begin
      b0  = {6'($urandom), words[i][17:16]};
      sum = sum + b0 + words[i][15:8] + words[i][7:0];
      strobe(b0);
      gap(gmin, gmax);
      strobe(words[i][15:8]);
      gap(gmin, gmax);
      strobe(words[i][7:0]);
      chk("wr_we", 32'(pm_we), 3);
      chk("wr_addr", 32'(pm_address), 32'(i[9:0]));
      chk("wr_data", 32'(pm_data), 32'(words[i]));
      tick();
      chk("wr_we_single", 32'(pm_we), 0);
      gap(gmin, gmax);
    end
    c = 8'h00 - sum;
    if (bad) c = c + 8'h01;
    strobe(c);
    resp = bad ? NAK : ACK;
    chk("resp_valid", 32'(tx_valid), 1);
    chk("resp_data", 32'(tx_data), 32'(resp));
    chk("resp_cpu_reset", 32'(cpu_reset), 1);
    chk("resp_pm_data_hold", 32'(pm_data), 32'(words[n-1]));
    chk("n_writes", wq.size(), n);
    nbad = 0;
    for (int unsigned i = 0; i < wq.size() && i < n; i++)
      if (wq[i] !== {4'b0011, i[9:0], words[i]}) nbad++;
    chk("write_log", nbad, 0);
    stray[0] = START; stray[1] = 8'h00; stray[2] = 8'h00;
    for (int unsigned k = 0; k < hold; k++) begin
      if (k % 3 == 1 && k / 3 < 3) strobe(stray[k/3]);
      else tick();
      chk("hold_valid", 32'(tx_valid), 1);
      chk("hold_data", 32'(tx_data), 32'(resp));
    end
    handshake(bad);
    if (hold > 0) begin
      repeat (4) tick();
      chk("hold_idle_busy", 32'(busy), 0);
      chk("hold_no_write", wq.size(), n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned lat;
    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_pm_we", 32'(pm_we), 0);
    chk("rst_pm_data", 32'(pm_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cpu_address = 10'h155;
    #1;
    chk("idle_pm_addr", 32'(pm_address), 32'h155);

    // Non-start bytes in IDLE are ignored
    for (int unsigned i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (b == START) b = 8'h5A;
      strobe(b);
    end
    chk("idle_ignore_busy", 32'(busy), 0);
    chk("idle_ignore_cpu_reset", 32'(cpu_reset), 0);

    // Directed N=2 load, then the same frame with a corrupted checksum
    words.delete();
    words.push_back(18'h21234);
    words.push_back(18'h0ABCD);
    run_frame(1'b0, 0, 0, 0);
    run_frame(1'b1, 0, 2, 0);

    // Timeout after A5 00 00 02
    wq.delete();
    strobe(START);
    strobe(8'h00);
    strobe(8'h00);
    strobe(8'h02);
    lat = 0;
    while (!tx_valid && lat < TO + 20) begin
      tick();
      lat++;
    end
    chk("to_seen", 32'(tx_valid), 1);
    chk("to_latency", 32'(lat >= TO - 1 && lat <= TO + 1), 1);
    chk("to_data", 32'(tx_data), 32'(NAK));
    chk("to_busy", 32'(busy), 1);
    chk("to_no_write", wq.size(), 0);
    handshake(1'b1);

    // Random frames, including one with near-timeout gaps
    for (int unsigned f = 0; f < 6; f++) begin
      words.delete();
      repeat ($urandom_range(40, 1)) words.push_back(18'($urandom));
      run_frame($urandom_range(3, 0) == 0, 0, 3, 0);
    end
    words.delete();
    repeat (2) words.push_back(18'($urandom));
    run_frame(1'b0, TO - 3, TO - 3, 0);

    // Full 1024-word load with data = address, then readback via cpu_address
    words.delete();
    for (int unsigned i = 0; i < 1024; i++) words.push_back(18'(i));
    run_frame(1'b0, 0, 1, 0);
    begin
      int unsigned rb_bad;
      rb_bad = 0;
      for (int unsigned i = 0; i < 1024; i++) begin
        cpu_address = 10'(i);
        #1;
        if (ram[pm_address] !== 18'(i)) rb_bad++;
      end
      chk("readback_errors", rb_bad, 0);
    end
    tick();

    // Reset mid-word, after the B1 byte
    strobe(START);
    strobe(8'h00);
    strobe(8'h00);
    strobe(8'h01);
    strobe(8'h22);
    rst_n = 1'b0;
    #1;
    exp_cpu_reset = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cpu_reset", 32'(cpu_reset), 0);
    chk("mid_rst_pm_we", 32'(pm_we), 0);
    chk("mid_rst_tx_valid", 32'(tx_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    words.delete();
    words.push_back(18'($urandom));
    run_frame(1'b0, 0, 2, 0);

    // tx_ready held low with stray bytes during RESP
    words.delete();
    words.push_back(18'($urandom));
    words.push_back(18'($urandom));
    run_frame(1'b0, 0, 1, 10);
    words.delete();
    words.push_back(18'($urandom));
    run_frame(1'b0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
